// File: rtl/led_pwm_pkg.sv
// Shared types and sizing helpers for the multi-channel LED PWM bank.
package led_pwm_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STEADY  = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    typedef enum logic {
        BR_RISE = 1'b0,
        BR_FALL = 1'b1
    } brth_dir_e;

    function automatic int period_cyc(input int clk_hz, input int pwm_hz);
        return clk_hz / pwm_hz;
    endfunction

    function automatic int step_cyc(input int clk_hz, input int pwm_hz, input int steps);
        return (clk_hz / pwm_hz) / steps;
    endfunction

    // Duty values run 0..DUTY_STEPS inclusive, so one extra code is needed.
    function automatic int duty_w(input int steps);
        return $clog2(steps + 1);
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pwm_bank_if.sv
// Configuration write port: one-cycle strobe carrying {channel, mode, duty}.
interface led_pwm_bank_if
    import led_pwm_pkg::*;
#(
    parameter int DUTY_W = 7
);
    logic              wr_en;
    logic [3:0]        wr_chan;
    mode_e             wr_mode;
    logic [DUTY_W-1:0] wr_duty;

    modport master (output wr_en, wr_chan, wr_mode, wr_duty);
    modport slave  (input  wr_en, wr_chan, wr_mode, wr_duty);
endinterface

// File: rtl/led_pwm_channel.sv
// One LED channel: shadow/active config, breathe level tracker, duty compare, output flop.
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int DUTY_STEPS   = 100,
    parameter int DEFAULT_DUTY = 10,
    parameter int DUTY_W       = 7,
    parameter int PHASE_W      = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_i,
    input  mode_e              wr_mode_i,
    input  logic [DUTY_W-1:0]  wr_duty_i,
    input  logic               boundary_i,
    input  logic               blink_on_i,
    input  logic               brth_tick_i,
    input  logic [PHASE_W-1:0] phase_i,
    output logic               led_o
);
    localparam logic [DUTY_W-1:0] STEPS = DUTY_W'(DUTY_STEPS);
    localparam logic [DUTY_W-1:0] DEF   = DUTY_W'(DEFAULT_DUTY);

    mode_e             shd_mode_q, shd_mode_d, act_mode_q, act_mode_d;
    logic [DUTY_W-1:0] shd_duty_q, shd_duty_d, act_duty_q, act_duty_d;
    logic [DUTY_W-1:0] lvl_q, lvl_d, lim, eff_duty;
    brth_dir_e         dir_q, dir_d;
    logic              led_q, led_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd_mode_q <= MODE_STEADY;
            shd_duty_q <= DEF;
            act_mode_q <= MODE_STEADY;
            act_duty_q <= DEF;
            lvl_q      <= '0;
            dir_q      <= BR_RISE;
            led_q      <= 1'b0;
        end else begin
            shd_mode_q <= shd_mode_d;
            shd_duty_q <= shd_duty_d;
            act_mode_q <= act_mode_d;
            act_duty_q <= act_duty_d;
            lvl_q      <= lvl_d;
            dir_q      <= dir_d;
            led_q      <= led_d;
        end
    end

    always_comb begin
        shd_mode_d = shd_mode_q;
        shd_duty_d = shd_duty_q;
        act_mode_d = act_mode_q;
        act_duty_d = act_duty_q;
        lvl_d      = lvl_q;
        dir_d      = dir_q;
        lim        = '0;
        eff_duty   = '0;
        led_d      = 1'b0;

        if (wr_i) begin
            shd_mode_d = wr_mode_i;
            shd_duty_d = wr_duty_i;
        end

        // The active copy and breathe level only move at a period boundary,
        // using the shadow including any write landing in the same cycle.
        if (boundary_i) begin
            act_mode_d = shd_mode_d;
            act_duty_d = shd_duty_d;
            lim        = (shd_duty_d > STEPS) ? STEPS : shd_duty_d;
            if (act_mode_q != MODE_BREATHE) begin
                lvl_d = '0;
                dir_d = BR_RISE;
            end else if (lvl_q > lim) begin
                lvl_d = lim;
                dir_d = BR_FALL;
            end else if (brth_tick_i) begin
                case (dir_q)
                    BR_RISE: begin
                        if (lvl_q < lim) begin
                            lvl_d = lvl_q + DUTY_W'(1);
                        end else begin
                            dir_d = BR_FALL;
                            if (lvl_q != '0) lvl_d = lvl_q - DUTY_W'(1);
                        end
                    end
                    default: begin
                        if (lvl_q != '0) begin
                            lvl_d = lvl_q - DUTY_W'(1);
                        end else begin
                            dir_d = BR_RISE;
                            if (lim != '0) lvl_d = lvl_q + DUTY_W'(1);
                        end
                    end
                endcase
            end
        end

        case (act_mode_q)
            MODE_OFF:    eff_duty = '0;
            MODE_STEADY: eff_duty = act_duty_q;
            MODE_BLINK:  eff_duty = blink_on_i ? act_duty_q : '0;
            default:     eff_duty = lvl_q;
        endcase
        led_d = (DUTY_W'(phase_i) < eff_duty);
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_pwm_bank.sv
// Multi-channel LED PWM driver: shared timebase, blink/breathe dividers and write decode.
module led_pwm_bank
    import led_pwm_pkg::*;
#(
    parameter int CLK_HZ        = 125_000_000,
    parameter int PWM_HZ        = 1000,
    parameter int NUM_LEDS      = 4,
    parameter int DUTY_STEPS    = 100,
    parameter int DEFAULT_DUTY  = 10,
    parameter int BLINK_PERIODS = 250,
    parameter int BREATHE_DIV   = 2,
    parameter bit ACTIVE_HIGH   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    led_pwm_bank_if.slave       cfg,
    output logic [NUM_LEDS-1:0] led
);
    localparam int STEP_CYC = step_cyc(CLK_HZ, PWM_HZ, DUTY_STEPS);
    localparam int DUTY_W   = duty_w(DUTY_STEPS);
    localparam int PRE_W    = cnt_w(STEP_CYC);
    localparam int PHASE_W  = cnt_w(DUTY_STEPS);
    localparam int BLK_W    = cnt_w(BLINK_PERIODS);
    localparam int BRW_W    = cnt_w(BREATHE_DIV);

    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [BLK_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic [BRW_W-1:0]   brth_cnt_q, brth_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic               pre_wrap, boundary, brth_tick, chan_ok;
    logic [NUM_LEDS-1:0] wr_sel, led_raw;

    assign pre_wrap  = (pre_q == PRE_W'(STEP_CYC - 1));
    assign boundary  = pre_wrap && (phase_q == PHASE_W'(DUTY_STEPS - 1));
    assign brth_tick = boundary && (brth_cnt_q == BRW_W'(BREATHE_DIV - 1));
    assign chan_ok   = cfg.wr_en && ({1'b0, cfg.wr_chan} < 5'(NUM_LEDS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q      <= '0;
            phase_q    <= '0;
            blk_cnt_q  <= '0;
            brth_cnt_q <= '0;
            blink_on_q <= 1'b1;
        end else begin
            pre_q      <= pre_d;
            phase_q    <= phase_d;
            blk_cnt_q  <= blk_cnt_d;
            brth_cnt_q <= brth_cnt_d;
            blink_on_q <= blink_on_d;
        end
    end

    always_comb begin
        pre_d      = pre_q + PRE_W'(1);
        phase_d    = phase_q;
        blk_cnt_d  = blk_cnt_q;
        brth_cnt_d = brth_cnt_q;
        blink_on_d = blink_on_q;
        if (pre_wrap) begin
            pre_d   = '0;
            phase_d = (phase_q == PHASE_W'(DUTY_STEPS - 1)) ? '0 : phase_q + PHASE_W'(1);
        end
        if (boundary) begin
            if (blk_cnt_q == BLK_W'(BLINK_PERIODS - 1)) begin
                blk_cnt_d  = '0;
                blink_on_d = ~blink_on_q;
            end else begin
                blk_cnt_d = blk_cnt_q + BLK_W'(1);
            end
            brth_cnt_d = brth_tick ? '0 : brth_cnt_q + BRW_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        assign wr_sel[i] = chan_ok && (cfg.wr_chan == 4'(i));

        led_pwm_channel #(
            .DUTY_STEPS   (DUTY_STEPS),
            .DEFAULT_DUTY (DEFAULT_DUTY),
            .DUTY_W       (DUTY_W),
            .PHASE_W      (PHASE_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .wr_i        (wr_sel[i]),
            .wr_mode_i   (cfg.wr_mode),
            .wr_duty_i   (cfg.wr_duty),
            .boundary_i  (boundary),
            .blink_on_i  (blink_on_q),
            .brth_tick_i (brth_tick),
            .phase_i     (phase_q),
            .led_o       (led_raw[i])
        );
    end

    // Polarity is applied after the flop, so an inverted bank resets to all ones.
    assign led = ACTIVE_HIGH ? led_raw : ~led_raw;

endmodule
